mips_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers. It serves the

---
 rtl/mips_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per clock, sign fixed at the end.
module mips_muldiv_unit #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [1:0]          op_q, op_d;
  logic [N-1:0]        ma_q, ma_d, mb_q, mb_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*N-1:0]      work_q, work_d;
  logic [N-1:0]        rem_q, rem_d;
  logic [N-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, dbz_q, dbz_d;

  // Operand magnitudes and sign bits for the incoming request
  logic                a_neg, b_neg;
  logic [N-1:0]        mag_a, mag_b;
  assign a_neg = ~op[0] & a[N-1];
  assign b_neg = ~op[0] & b[N-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // Multiply: upper half accumulates, multiplier bits shift out of the lower half
  logic [N:0]          add_sum;
  assign add_sum = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, ma_q} : '0);

  // Divide: work_q[N-1:0] holds the dividend shifting out and quotient shifting in
  logic [N:0]          shifted, trial;
  assign shifted = {rem_q, work_q[N-1]};
  assign trial   = shifted - {1'b0, mb_q};

  logic [2*N-1:0]      prod_fix;
  logic [N-1:0]        quo_fix, rem_fix;
  assign prod_fix = neg_q ? -work_q : work_q;
  assign quo_fix  = neg_q ? -work_q[N-1:0] : work_q[N-1:0];
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          // Latched request: either finish at once on a zero divisor or seed the datapath
          pend_d = 1'b0;
          if (op_q[1] && (mb_q == '0)) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d = StRun;
            rem_d   = '0;
            work_d  = op_q[1] ? {{N{1'b0}}, ma_q} : {{N{1'b0}}, mb_q};
          end
        end else if (start) begin
          pend_d = 1'b1;
          op_d   = op;
          ma_d   = mag_a;
          mb_d   = mag_b;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg & op[1];
          cnt_d  = '0;
        end else begin
          if (hi_we) hi_d = wr_data;
          if (lo_we) lo_d = wr_data;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (op_q[1]) begin
          if (trial[N]) begin
            rem_d  = shifted[N-1:0];
            work_d = {work_q[2*N-1:N], work_q[N-2:0], 1'b0};
          end else begin
            rem_d  = trial[N-1:0];
            work_d = {work_q[2*N-1:N], work_q[N-2:0], 1'b1};
          end
        end else begin
          work_d = {add_sum, work_q[N-1:1]};
        end
        if (cnt_q == CntW'(N - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*N-1:N];
          lo_d = prod_fix[N-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      op_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op_q    <= op_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: an arithmetic timeline model checked every cycle,
// plus hand-computed literal results and latencies.
module tb_mips_muldiv_unit;
  localparam int unsigned N = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wr_data = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mips_muldiv_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain integer arithmetic: {hi, lo}
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p, q, r;
    sx = o[0] ? longint'({32'h0, x}) : longint'($signed(x));
    sy = o[0] ? longint'({32'h0, y}) : longint'($signed(y));
    if (!o[1]) begin
      p = 64'(sx * sy);
      return p;
    end
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {r[31:0], q[31:0]};
  endfunction

  // Timeline model: an accepted request completes N+2 edges later (1 edge for divide-by-zero)
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] p_res = '0;
  int          rem_cyc = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dbz   <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      rem_cyc <= 0;
      p_dbz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (rem_cyc > 0) begin
        rem_cyc <= rem_cyc - 1;
        m_busy  <= (rem_cyc > 1) && !p_dbz;
        if (rem_cyc == 1) begin
          m_done <= 1'b1;
          m_dbz  <= p_dbz;
          if (!p_dbz) begin
            m_hi <= p_res[63:32];
            m_lo <= p_res[31:0];
          end
        end
      end else if (start) begin
        m_busy <= 1'b0;
        if (op[1] && (b == 32'h0)) begin
          p_dbz   <= 1'b1;
          rem_cyc <= 1;
        end else begin
          p_dbz   <= 1'b0;
          rem_cyc <= N + 2;
          p_res   <= ref_result(op, a, b);
        end
      end else begin
        if (hi_we) m_hi <= wr_data;
        if (lo_we) m_lo <= wr_data;
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {63'b0, busy}, {63'b0, m_busy});
    check("done", {63'b0, done}, {63'b0, m_done});
    check("div_by_zero", {63'b0, div_by_zero}, {63'b0, m_dbz});
    check("hi", {32'b0, hi}, {32'b0, m_hi});
    check("lo", {32'b0, lo}, {32'b0, m_lo});
  end

  // All drivers enter and leave at 1 time unit after a rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3));
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    if (!done) check("done_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    issue(o, x, y);
    wait_done(lat, bcnt);
  endtask

  task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wr_data = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = $urandom;
  endtask

  int lat, bc;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    @(posedge clk); #1;

    // MULTU max*max, latency and busy width
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    check("t1_lat", 64'(lat), 64'd34);
    check("t1_busy_cycles", 64'(bc), 64'd33);
    check("t1_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    check("t1_lo", {32'b0, lo}, 64'h0000_0001);

    // Signed multiplies, issued back-to-back in the done cycle
    run_op(2'b00, -32'sd3, 32'd5, lat, bc);
    check("t2a_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("t2a_lo", {32'b0, lo}, 64'hFFFF_FFF1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bc);
    check("t2b_hi", {32'b0, hi}, 64'h4000_0000);
    check("t2b_lo", {32'b0, lo}, 64'h0);

    // Divides
    run_op(2'b10, -32'sd7, 32'd2, lat, bc);
    check("t3a_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("t3a_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    run_op(2'b11, 32'd7, 32'd2, lat, bc);
    check("t3b_lo", {32'b0, lo}, 64'd3);
    check("t3b_hi", {32'b0, hi}, 64'd1);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    check("t3c_lo", {32'b0, lo}, 64'h8000_0000);
    check("t3c_hi", {32'b0, hi}, 64'h0);
    run_op(2'b10, 32'd100, -32'sd7, lat, bc);
    check("t3d_lo", {32'b0, lo}, 64'hFFFF_FFF2);
    check("t3d_hi", {32'b0, hi}, 64'd2);

    // MTHI+MTLO together, then separate preloads and a divide by zero
    mt(1'b1, 1'b1, 32'h55);
    check("t4_both_hi", {32'b0, hi}, 64'h55);
    check("t4_both_lo", {32'b0, lo}, 64'h55);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    run_op(2'b11, 32'd7, 32'd0, lat, bc);
    check("t4_lat", 64'(lat), 64'd1);
    check("t4_dbz", {63'b0, div_by_zero}, 64'd1);
    check("t4_busy_cycles", 64'(bc), 64'd0);
    check("t4_hi", {32'b0, hi}, 64'h11);
    check("t4_lo", {32'b0, lo}, 64'h22);

    // Start and MTHI while busy are both dropped
    issue(2'b01, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    op = 2'b01; a = 32'd1; b = 32'd1; start = 1'b1; hi_we = 1'b1; wr_data = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat, bc);
    check("t5_lat", 64'(lat + 5), 64'd34);
    check("t5_lo", {32'b0, lo}, 64'd42);
    check("t5_hi", {32'b0, hi}, 64'd0);
    repeat (3) @(posedge clk);
    #1 check("t5_idle_busy", {63'b0, busy}, 64'd0);

    // Asynchronous reset mid-run, then a normal operation
    issue(2'b01, 32'd5, 32'd9);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_busy", {63'b0, busy}, 64'd0);
    check("t6_done", {63'b0, done}, 64'd0);
    check("t6_hi", {32'b0, hi}, 64'd0);
    check("t6_lo", {32'b0, lo}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    run_op(2'b01, 32'd2, 32'd3, lat, bc);
    check("t6_lat", 64'(lat), 64'd34);
    check("t6_lo_after", {32'b0, lo}, 64'd6);
    check("t6_hi_after", {32'b0, hi}, 64'd0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
